region_hit_filter: RTL and testbench
====================================

REGION_HIT_FILTER -- requirements
Module: region_hit_filter

Interface
REQ-001 SHALL have parameter ON_FRAMES, default 3: consecutive frames with a region seen before a hit is declared (range 1..15).
REQ-002 SHALL have parameter OFF_FRAMES, default 2: consecutive frames with a region absent before a held hit is released (range 1..15).
REQ-003 SHALL have parameter N_REGIONS, default 4: number of screen regions (red, green, yellow, blue lanes).
REQ-004 CLOCK_24  input  1  single clock; every flop SHALL be on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 frame_tick  input  1  one-cycle pulse marking end of camera frame (VSYNC edge).
REQ-007 region_flag  input  N_REGIONS  per-region detection level from the colour trackers; bit 0 = red lane.
REQ-008 hit_level  output  N_REGIONS  high while a region hit is held.
REQ-009 hit_press  output  N_REGIONS  one-cycle pulse when a hit is declared.
REQ-010 hit_release  output  N_REGIONS  one-cycle pulse when a held hit ends.

Function
REQ-011 Per region, a seen latch SHALL set on any cycle with region_flag high; the frame's seen value SHALL be latch OR region_flag in the frame_tick cycle; the latch SHALL clear on frame_tick.
REQ-012 Each region SHALL run an independent FSM with states IDLE, ARM, HELD, DROP and a 4-bit frame counter; transitions occur only in frame_tick cycles.
REQ-013 IDLE: seen -> ARM, cnt=1; if ON_FRAMES==1 -> HELD directly with press. Not seen -> stay IDLE.
REQ-014 ARM: seen -> cnt+1; when cnt+1==ON_FRAMES -> HELD, cnt=0, press. Not seen -> IDLE, cnt=0, no pulse.
REQ-015 HELD: seen -> stay. Not seen -> DROP, cnt=1; if OFF_FRAMES==1 -> IDLE directly with release.
REQ-016 DROP: seen -> HELD, cnt=0, no press. Not seen -> cnt+1; when cnt+1==OFF_FRAMES -> IDLE, cnt=0, release.
REQ-017 hit_press/hit_release SHALL be registered, asserted exactly the cycle after the deciding frame_tick, for one cycle.
REQ-018 hit_level SHALL be registered, high when state is HELD or DROP; it rises in the same cycle as hit_press and falls in the same cycle as hit_release.
REQ-019 hit_press and hit_release SHALL never be high together for one region; different regions MAY pulse in the same cycle.
REQ-020 frame_tick on back-to-back cycles SHALL each count as a frame; the second sees only that cycle's region_flag.
REQ-021 Counter SHALL saturate at 15, never wrap.

Reset
REQ-022 rst high SHALL force all FSMs to IDLE, counters and seen latches to 0, all outputs to 0 on the next edge.
REQ-023 Reset while HELD SHALL NOT produce a hit_release pulse.
REQ-024 rst SHALL take priority over a coincident frame_tick.

Configuration
REQ-025 Macro REGION_HIT_RELEASE_DEBOUNCE_EN defined: DROP state and OFF_FRAMES behave per REQ-015/016.
REQ-026 Macro undefined: DROP state SHALL NOT exist; HELD with not-seen SHALL go directly to IDLE with release; OFF_FRAMES ignored.

Structure
REQ-027 Package region_hit_pkg SHALL hold the FSM state enum, N_REGIONS default and counter width constant.
REQ-028 Sub-module region_hit_fsm SHALL implement one region (seen latch, FSM, counter, output regs); top instantiates N_REGIONS copies via generate.

Verification
REQ-029 ON_FRAMES=3: region_flag[0] high for 3 frames -> hit_press[0] one cycle after 3rd frame_tick, hit_level[0]=1.
REQ-030 Flag high 2 frames, low 1, high 3 -> single hit_press only after the final 3rd consecutive frame.
REQ-031 Macro on, OFF_FRAMES=2: held region absent 1 frame then present -> no release, hit_level stays 1; absent 2 frames -> hit_release one cycle after 2nd tick.
REQ-032 Macro off: held region absent 1 frame -> hit_release and hit_level=0 one cycle after that tick.
REQ-033 Single-cycle region_flag pulse mid-frame -> counts as seen at next frame_tick; all 4 regions driven together -> 4 simultaneous press pulses.
REQ-034 rst asserted while region 2 HELD and coincident with frame_tick -> all outputs 0 next cycle, no release pulse, re-arm needs ON_FRAMES fresh frames.

Source files
------------

// File: rtl/region_hit_pkg.sv
// Shared types and constants for the region hit filter.
// Optional feature macro: REGION_HIT_RELEASE_DEBOUNCE_EN adds the DROP state
// so that a held hit is released only after OFF_FRAMES consecutive absent frames.
package region_hit_pkg;

  localparam int N_REGIONS_DEFAULT = 4;
  localparam int CNT_W             = 4;
  localparam logic [CNT_W-1:0] CNT_MAX = 4'd15;

`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2,
    DROP = 2'd3
  } hit_state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    HELD = 2'd2
  } hit_state_t;
`endif

  // Frame counter increment that sticks at the maximum instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_MAX) begin
      cnt_inc = CNT_MAX;
    end else begin
      cnt_inc = cnt + 4'd1;
    end
  endfunction

endpackage

// File: rtl/region_hit_fsm.sv
// One region of the hit filter: per-frame seen latch, debounce FSM,
// saturating frame counter and registered level/press/release outputs.
// Optional feature macro: REGION_HIT_RELEASE_DEBOUNCE_EN (release debounce).
module region_hit_fsm
  import region_hit_pkg::*;
#(
  parameter int ON_FRAMES  = 3
`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
  ,
  parameter int OFF_FRAMES = 2
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic flag,
  output logic hit_level,
  output logic hit_press,
  output logic hit_release
);

  localparam logic [CNT_W-1:0] ON_CNT = ON_FRAMES[CNT_W-1:0];
`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] OFF_CNT = OFF_FRAMES[CNT_W-1:0];
`endif

  hit_state_t       state_r;
  hit_state_t       state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] cnt_plus_s;
  logic             seen_r;
  logic             seen_s;
  logic             press_nxt_s;
  logic             release_nxt_s;
  logic             level_nxt_s;

  // Frame verdict: anything latched earlier in the frame, or the flag in the tick cycle itself.
  always_comb begin
    seen_s = seen_r | flag;
  end

  // Next-state, counter and pulse decode; decisions are taken only in frame_tick cycles.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    press_nxt_s   = 1'b0;
    release_nxt_s = 1'b0;
    cnt_plus_s    = cnt_inc(cnt_r);
    if (frame_tick) begin
      case (state_r)
        IDLE: begin
          if (seen_s) begin
            if (ON_CNT == 4'd1) begin
              state_nxt_s = HELD;
              cnt_nxt_s   = 4'd0;
              press_nxt_s = 1'b1;
            end else begin
              state_nxt_s = ARM;
              cnt_nxt_s   = 4'd1;
            end
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
          end
        end
        ARM: begin
          if (seen_s) begin
            if (cnt_plus_s == ON_CNT) begin
              state_nxt_s = HELD;
              cnt_nxt_s   = 4'd0;
              press_nxt_s = 1'b1;
            end else begin
              state_nxt_s = ARM;
              cnt_nxt_s   = cnt_plus_s;
            end
          end else begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 4'd0;
          end
        end
        HELD: begin
          if (seen_s) begin
            state_nxt_s = HELD;
            cnt_nxt_s   = 4'd0;
          end else begin
`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
            if (OFF_CNT == 4'd1) begin
              state_nxt_s   = IDLE;
              cnt_nxt_s     = 4'd0;
              release_nxt_s = 1'b1;
            end else begin
              state_nxt_s = DROP;
              cnt_nxt_s   = 4'd1;
            end
`else
            state_nxt_s   = IDLE;
            cnt_nxt_s     = 4'd0;
            release_nxt_s = 1'b1;
`endif
          end
        end
`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
        DROP: begin
          if (seen_s) begin
            state_nxt_s = HELD;
            cnt_nxt_s   = 4'd0;
          end else if (cnt_plus_s == OFF_CNT) begin
            state_nxt_s   = IDLE;
            cnt_nxt_s     = 4'd0;
            release_nxt_s = 1'b1;
          end else begin
            state_nxt_s = DROP;
            cnt_nxt_s   = cnt_plus_s;
          end
        end
`endif
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
    end
  end

  // Level follows the state being entered so it moves on the same edge as the pulses.
  always_comb begin
`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
    level_nxt_s = (state_nxt_s == HELD) || (state_nxt_s == DROP);
`else
    level_nxt_s = (state_nxt_s == HELD);
`endif
  end

  // State, counter, seen latch and output registers; reset wins over frame_tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      seen_r      <= 1'b0;
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      hit_level   <= 1'b0;
      hit_press   <= 1'b0;
      hit_release <= 1'b0;
    end else begin
      if (frame_tick) begin
        seen_r <= 1'b0;
      end else if (flag) begin
        seen_r <= 1'b1;
      end else begin
        seen_r <= seen_r;
      end
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      hit_level   <= level_nxt_s;
      hit_press   <= press_nxt_s;
      hit_release <= release_nxt_s;
    end
  end

endmodule

// File: rtl/region_hit_filter.sv
// Region hit filter top: one independent debounce FSM per screen region.
// Optional feature macro: REGION_HIT_RELEASE_DEBOUNCE_EN (OFF_FRAMES release
// debounce); when undefined a held hit drops on the first absent frame.
module region_hit_filter
  import region_hit_pkg::*;
#(
  parameter int ON_FRAMES  = 3,
  parameter int OFF_FRAMES = 2,
  parameter int N_REGIONS  = N_REGIONS_DEFAULT
) (
  input  logic                 CLOCK_24,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [N_REGIONS-1:0] region_flag,
  output logic [N_REGIONS-1:0] hit_level,
  output logic [N_REGIONS-1:0] hit_press,
  output logic [N_REGIONS-1:0] hit_release
);

  // Frame counts must fit the 4-bit counter and be non-zero.
  if ((ON_FRAMES < 1) || (ON_FRAMES > 15) || (OFF_FRAMES < 1) || (OFF_FRAMES > 15)) begin : g_bad_frames
    $error("region_hit_filter: ON_FRAMES/OFF_FRAMES must be in 1..15");
  end

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
    region_hit_fsm #(
      .ON_FRAMES (ON_FRAMES)
`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
      ,
      .OFF_FRAMES(OFF_FRAMES)
`endif
    ) u_fsm (
      .clk        (CLOCK_24),
      .rst        (rst),
      .frame_tick (frame_tick),
      .flag       (region_flag[g]),
      .hit_level  (hit_level[g]),
      .hit_press  (hit_press[g]),
      .hit_release(hit_release[g])
    );
  end

endmodule

// File: tb/tb_region_hit_filter.sv
// Self-checking bench for region_hit_filter (ON_FRAMES=3, OFF_FRAMES=2, 4 regions).
// A streak-counting model predicts outputs every cycle; directed scenarios add
// hand-computed literal checks. Follows REGION_HIT_RELEASE_DEBOUNCE_EN if defined.
module tb_region_hit_filter;

  localparam int ON  = 3;
`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
  localparam int OFF_EFF = 2;
`else
  localparam int OFF_EFF = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic [3:0] region_flag = 4'b0000;
  logic [3:0] hit_level;
  logic [3:0] hit_press;
  logic [3:0] hit_release;

  int vectors = 0;
  int miscompares = 0;

  region_hit_filter #(
    .ON_FRAMES (3),
    .OFF_FRAMES(2),
    .N_REGIONS (4)
  ) dut (
    .CLOCK_24   (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .region_flag(region_flag),
    .hit_level  (hit_level),
    .hit_press  (hit_press),
    .hit_release(hit_release)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per region count consecutive seen frames while not held,
  // consecutive absent frames while held.
  int         streak [4];
  int         absent [4];
  bit         held   [4];
  bit         acc    [4];
  logic [3:0] exp_level   = 4'b0000;
  logic [3:0] exp_press   = 4'b0000;
  logic [3:0] exp_release = 4'b0000;
  bit         checking    = 1'b0;

  always @(negedge clk) begin
    if (checking) begin
      chk("cyc_level", hit_level, exp_level);
      chk("cyc_press", hit_press, exp_press);
      chk("cyc_release", hit_release, exp_release);
    end
    exp_press   = 4'b0000;
    exp_release = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        streak[i] = 0;
        absent[i] = 0;
        held[i]   = 1'b0;
        acc[i]    = 1'b0;
      end else if (frame_tick) begin
        bit seen;
        seen   = acc[i] | region_flag[i];
        acc[i] = 1'b0;
        if (!held[i]) begin
          streak[i] = seen ? streak[i] + 1 : 0;
          if (streak[i] == ON) begin
            held[i] = 1'b1;
            streak[i] = 0;
            exp_press[i] = 1'b1;
          end
        end else begin
          absent[i] = seen ? 0 : absent[i] + 1;
          if (absent[i] == OFF_EFF) begin
            held[i] = 1'b0;
            absent[i] = 0;
            exp_release[i] = 1'b1;
          end
        end
      end else begin
        acc[i] = acc[i] | region_flag[i];
      end
      exp_level[i] = held[i];
    end
  end

  // One clock with the given inputs; returns just after the edge so outputs are settled.
  task automatic cyc(input logic [3:0] f, input logic t, input logic r);
    region_flag = f;
    frame_tick  = t;
    rst         = r;
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [3:0] f);
    cyc(f, 1'b1, 1'b0);
  endtask

  task automatic gap(input int n);
    repeat (n) cyc(4'b0000, 1'b0, 1'b0);
  endtask

  initial begin
    cyc(4'b0000, 1'b0, 1'b1);
    checking = 1'b1;
    cyc(4'b0000, 1'b0, 1'b1);
    chk("reset_level", hit_level, 4'b0000);
    chk("reset_press", hit_press, 4'b0000);
    chk("reset_release", hit_release, 4'b0000);

    // Three seen frames on red lane declare a hit.
    frame(4'b0001); gap(2);
    frame(4'b0001); gap(2);
    chk("arm2_press", hit_press, 4'b0000);
    frame(4'b0001);
    chk("on3_press", hit_press, 4'b0001);
    chk("on3_level", hit_level, 4'b0001);
    gap(1);
    chk("on3_press_end", hit_press, 4'b0000);
    chk("on3_level_hold", hit_level, 4'b0001);

    // Release behaviour.
`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
    frame(4'b0000);
    chk("drop1_release", hit_release, 4'b0000);
    chk("drop1_level", hit_level, 4'b0001);
    gap(1);
    frame(4'b0001);
    chk("rehold_press", hit_press, 4'b0000);
    chk("rehold_level", hit_level, 4'b0001);
    gap(1);
    frame(4'b0000); gap(1);
    frame(4'b0000);
    chk("off2_release", hit_release, 4'b0001);
    chk("off2_level", hit_level, 4'b0000);
`else
    frame(4'b0000);
    chk("off1_release", hit_release, 4'b0001);
    chk("off1_level", hit_level, 4'b0000);
    chk("off1_press", hit_press, 4'b0000);
`endif
    gap(1);
    chk("release_end", hit_release, 4'b0000);

    // Interrupted streak on green lane: 2 seen, 1 absent, then 3 seen.
    frame(4'b0010); gap(1);
    frame(4'b0010); gap(1);
    frame(4'b0000); gap(1);
    frame(4'b0010); gap(1);
    frame(4'b0010);
    chk("broken_press", hit_press, 4'b0000);
    gap(1);
    frame(4'b0010);
    chk("streak_press", hit_press, 4'b0010);
    chk("streak_level", hit_level, 4'b0010);
    frame(4'b0000);
    frame(4'b0000);
    chk("b2b_release_level", hit_level, 4'b0000);
    gap(1);

    // Back-to-back ticks: second tick sees only its own flag.
    cyc(4'b0001, 1'b0, 1'b0);
    frame(4'b0001);
    frame(4'b0000);
    frame(4'b0001);
    frame(4'b0001);
    chk("b2b_no_press", hit_press, 4'b0000);
    frame(4'b0001);
    chk("b2b_press", hit_press, 4'b0001);
    frame(4'b0000);
    frame(4'b0000);
    chk("b2b_clear", hit_level, 4'b0000);
    gap(1);

    // Single-cycle mid-frame pulses on all four lanes.
    for (int k = 0; k < 3; k++) begin
      cyc(4'b1111, 1'b0, 1'b0);
      gap(2);
      frame(4'b0000);
      if (k == 1) chk("pulse_arm_press", hit_press, 4'b0000);
    end
    chk("pulse_press_all", hit_press, 4'b1111);
    chk("pulse_level_all", hit_level, 4'b1111);
    frame(4'b0000);
`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
    chk("all_drop_release", hit_release, 4'b0000);
`else
    chk("all_release", hit_release, 4'b1111);
`endif
    frame(4'b1000);
`ifdef REGION_HIT_RELEASE_DEBOUNCE_EN
    chk("mixed_release", hit_release, 4'b0111);
    chk("mixed_level", hit_level, 4'b1000);
`else
    chk("mixed_release", hit_release, 4'b0000);
    chk("mixed_level", hit_level, 4'b0000);
`endif
    frame(4'b0000);
    frame(4'b0000);
    gap(1);
    chk("all_clear", hit_level, 4'b0000);

    // Reset while yellow lane held, coincident with frame_tick.
    frame(4'b0100); gap(1);
    frame(4'b0100); gap(1);
    frame(4'b0100);
    chk("y_press", hit_press, 4'b0100);
    gap(2);
    cyc(4'b0100, 1'b1, 1'b1);
    chk("rst_level", hit_level, 4'b0000);
    chk("rst_release", hit_release, 4'b0000);
    chk("rst_press", hit_press, 4'b0000);
    gap(1);
    chk("rst_release_after", hit_release, 4'b0000);
    frame(4'b0100); gap(1);
    frame(4'b0100);
    chk("rearm_press", hit_press, 4'b0000);
    chk("rearm_level", hit_level, 4'b0000);
    gap(1);
    frame(4'b0100);
    chk("rearm_done", hit_press, 4'b0100);
    gap(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
